quad_enc_ctrl: RTL and testbench
================================

Name: quad_enc_ctrl

Overview:
- Sequencing/configuration controller for the 64-bit quadrature encoder counter.
- Owns the encoder's reset line; executes host commands (zero, arm index capture, clear fault) through a valid/ready handshake.
- Produces periodic velocity samples and a sticky fault flag.
- Sits between the host register file and the encoder counter.

Parameters:
VEL_W, 32, width of signed velocity output (2..63)
PERIOD_W, 32, width of sample_period

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
enc_count  in  64  signed encoder count
enc_faultn  in  1  encoder fault, active-low
z  in  1  asynchronous index input
cmd_valid  in  1  command request
cmd_op  in  2  00 NOP/CANCEL, 01 ZERO, 10 ARM_INDEX, 11 CLR_FAULT
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clk edge
sample_period  in  PERIOD_W  velocity window in clk cycles; 0 disables sampling
enc_resetn  out  1  synchronous reset to encoder, active-low
velocity  out  VEL_W  signed count delta over last window, saturated
velocity_valid  out  1  one-cycle pulse with new velocity
index_pos  out  64  enc_count captured at index edge
index_valid  out  1  one-cycle pulse with new index_pos
fault_sticky  out  1  latched fault
state  out  2  00 IDLE, 01 ZERO, 10 ARMED

Behaviour:
- Reset (resetn=0), all registered:
  - state=IDLE; enc_resetn=0 (encoder held in reset).
  - cmd_ready=0; velocity=0; velocity_valid=0; index_pos=0; index_valid=0; fault_sticky=0.
  - Window counter=0; last_count=0; z synchronizer cleared.
- First cycle after reset release: enc_resetn=1.
- cmd_ready = (state!=ZERO) & resetn, combinational from registered state.
- z: two-flop synchronizer plus previous-value flop; index edge = rising edge of synchronized z, detected 3 cycles after the z pin rises.
- IDLE, on accepted command:
  - 00: no effect.
  - 01: goto ZERO.
  - 10: goto ARMED.
  - 11: clear fault.
- ZERO:
  - Lasts exactly 1 cycle with enc_resetn=0; last_count<=0; window counter<=0; then IDLE.
  - Command accepted at edge N: enc_resetn low during cycle N+1; enc_count==0 visible from N+2.
- ARMED, on accepted command:
  - 00: cancel to IDLE.
  - 01: ZERO (arm cancelled).
  - 10: stay ARMED.
  - 11: clear fault, stay ARMED.
- ARMED, on index edge: index_pos<=enc_count; index_valid pulses next cycle; goto IDLE.
- ARMED, index edge and accepted command in the same cycle:
  - Capture still occurs.
  - Next state is taken from the command: 00→IDLE, 01→ZERO, 10→ARMED, 11→IDLE with fault cleared.
- Index edges outside ARMED: ignored.
- Velocity:
  - If sample_period==0: counter held 0, no pulses.
  - Otherwise the counter increments every cycle. When counter==sample_period-1:
    - diff = enc_count - last_count (65-bit signed).
    - velocity <= diff saturated to [-2^(VEL_W-1), 2^(VEL_W-1)-1].
    - last_count <= enc_count; counter<=0; velocity_valid pulses 1 cycle.
  - sample_period changed mid-window: compare uses the new value. If counter ≥ new value, the counter keeps counting up and wraps at 2^PERIOD_W, with no glitch pulse.
  - ZERO restarts the window and suppresses any pulse that would coincide with it.
- Fault:
  - fault_sticky<=1 on any cycle with enc_faultn==0 (not in ZERO).
  - CLR_FAULT clears it only if enc_faultn==1 that cycle; set wins.
  - Because the encoder fault persists until encoder reset, the host issues ZERO then CLR_FAULT.
- resetn low mid-operation: immediate return to reset values; pending capture discarded.

Optional Feature:
- Macro: QUAD_ENC_INDEX_AUTOZERO_EN.
- Defined: on an index edge in ARMED, after capture the next state is ZERO (encoder zeroed at index), unless the same-cycle command is 00 (→IDLE) or 10 (→ARMED).
- Undefined: index capture only, as above.

Test Plan:
- Reset release, idle 4 cycles → enc_resetn 0 during reset, 1 from first cycle after; all outputs 0; cmd_ready=1.
- enc_count=1234, cmd ZERO accepted at edge N → state=ZERO and cmd_ready=0 in cycle N+1, enc_resetn=0 only in N+1, back IDLE at N+2.
- sample_period=100; enc_count +5 per cycle, with +1000 delta relative to previous window start → velocity_valid every 100 cycles, velocity=500 (or 1000 per window stimulus); with VEL_W=8 and delta 300 → velocity=127; delta -300 → -128.
- ARM_INDEX, enc_count=0x100, pulse z → index_valid 3-4 cycles after z rise with index_pos=0x100; state IDLE; second z pulse → no index_valid.
- Drive enc_faultn=0 1 cycle → fault_sticky=1; CLR_FAULT while enc_faultn=0 → stays 1; after enc_faultn=1, CLR_FAULT → 0.
- ARMED, index edge coincident with cmd 00 → index_valid pulses, state IDLE; with QUAD_ENC_INDEX_AUTOZERO_EN and no cmd → capture then enc_resetn low one cycle.

Source files
------------

// File: rtl/quad_enc_ctrl.sv
// -----------------------------------------------------------------------------
// quad_enc_ctrl
//
// Sequencing/configuration controller for a 64-bit quadrature encoder counter.
// It sits between the host register file and the encoder counter.
//   - Owns the encoder reset line (enc_resetn).
//   - Executes host commands (zero, arm index capture, clear fault).
//   - Produces periodic, saturated velocity samples.
//   - Keeps a sticky fault flag.
//
// Optional feature (compile-time macro QUAD_ENC_INDEX_AUTOZERO_EN):
//   When defined, an index capture taken in ARMED is followed by a ZERO cycle.
//   The exception is a same-cycle command of NOP (-> IDLE) or ARM (-> ARMED).
//
// Ports:
//   clk, resetn        clock; synchronous active-low reset
//   enc_count[63:0]    signed encoder count
//   enc_faultn         encoder fault, active-low
//   z                  asynchronous index input
//   cmd_valid/cmd_op   host command request (00 NOP/CANCEL, 01 ZERO,
//                      10 ARM_INDEX, 11 CLR_FAULT)
//   cmd_ready          command acceptance
//   sample_period      velocity window in clk cycles (0 disables sampling)
//   enc_resetn         registered synchronous reset to the encoder, active-low
//   velocity           signed count delta over the last window, saturated
//   velocity_valid     one-cycle pulse with a new velocity
//   index_pos          enc_count captured at the index edge
//   index_valid        one-cycle pulse with a new index_pos
//   fault_sticky       latched fault
//   state              controller state (00 IDLE, 01 ZERO, 10 ARMED)
//
// Handshake: a command transfers on a rising clk edge where
// cmd_valid & cmd_ready are both 1. cmd_ready is combinational from the
// registered state and resetn only. cmd_ready never depends on cmd_valid.
// The host may hold cmd_valid until it sees the transfer.
// -----------------------------------------------------------------------------
module quad_enc_ctrl #(
  parameter int VEL_W    = 32,
  parameter int PERIOD_W = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [63:0]                enc_count,
  input  logic                       enc_faultn,
  input  logic                       z,
  input  logic                       cmd_valid,
  input  logic [1:0]                 cmd_op,
  output logic                       cmd_ready,
  input  logic [PERIOD_W-1:0]        sample_period,
  output logic                       enc_resetn,
  output logic signed [VEL_W-1:0]    velocity,
  output logic                       velocity_valid,
  output logic [63:0]                index_pos,
  output logic                       index_valid,
  output logic                       fault_sticky,
  output logic [1:0]                 state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ZERO  = 2'b01,
    ST_ARMED = 2'b10
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ZERO = 2'b01;
  localparam logic [1:0] OP_ARM = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  // Saturation bounds for the 65-bit window difference.
  localparam logic signed [64:0] VEL_MAX = (65'sd1 <<< (VEL_W - 1)) - 65'sd1;
  localparam logic signed [64:0] VEL_MIN = -(65'sd1 <<< (VEL_W - 1));

  state_t                    state_q, state_d;
  logic                      enc_resetn_q, enc_resetn_d;
  logic signed [VEL_W-1:0]   velocity_q, velocity_d;
  logic                      velocity_valid_q, velocity_valid_d;
  logic [63:0]               index_pos_q, index_pos_d;
  logic                      index_valid_q, index_valid_d;
  logic                      fault_sticky_q, fault_sticky_d;
  logic [PERIOD_W-1:0]       win_cnt_q, win_cnt_d;
  logic [63:0]               last_count_q, last_count_d;
  logic                      z_meta_q, z_meta_d;
  logic                      z_sync_q, z_sync_d;
  logic                      z_prev_q, z_prev_d;

  logic                      cmd_fire;
  logic                      index_edge;
  logic                      clr_req;
  logic signed [64:0]        diff;

  assign cmd_ready      = (state_q != ST_ZERO) & resetn;
  assign cmd_fire       = cmd_valid & cmd_ready;
  assign index_edge     = z_sync_q & ~z_prev_q;
  assign diff           = $signed({enc_count[63], enc_count})
                        - $signed({last_count_q[63], last_count_q});

  assign state          = state_q;
  assign enc_resetn     = enc_resetn_q;
  assign velocity       = velocity_q;
  assign velocity_valid = velocity_valid_q;
  assign index_pos      = index_pos_q;
  assign index_valid    = index_valid_q;
  assign fault_sticky   = fault_sticky_q;

  // Next-state and command decode.
  always_comb begin
    state_d       = state_q;
    clr_req       = 1'b0;
    index_pos_d   = index_pos_q;
    index_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_ZERO: state_d = ST_ZERO;
            OP_ARM:  state_d = ST_ARMED;
            OP_CLR:  clr_req = 1'b1;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_ZERO: state_d = ST_IDLE;
      ST_ARMED: begin
        if (index_edge) begin
          index_pos_d   = enc_count;
          index_valid_d = 1'b1;
`ifdef QUAD_ENC_INDEX_AUTOZERO_EN
          state_d = ST_ZERO;
`else
          state_d = ST_IDLE;
`endif
          // A same-cycle command still decides where we go after capture.
          if (cmd_fire) begin
            case (cmd_op)
              OP_NOP:  state_d = ST_IDLE;
              OP_ZERO: state_d = ST_ZERO;
              OP_ARM:  state_d = ST_ARMED;
              default: begin
                clr_req = 1'b1;
`ifdef QUAD_ENC_INDEX_AUTOZERO_EN
                state_d = ST_ZERO;
`else
                state_d = ST_IDLE;
`endif
              end
            endcase
          end
        end else if (cmd_fire) begin
          case (cmd_op)
            OP_NOP:  state_d = ST_IDLE;
            OP_ZERO: state_d = ST_ZERO;
            OP_ARM:  state_d = ST_ARMED;
            default: clr_req = 1'b1;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The encoder reset is registered from the next state.
  // It is therefore low exactly during the cycle spent in ZERO.
  assign enc_resetn_d = (state_d != ST_ZERO);

  // Index synchronizer: two flops plus a previous-value flop for edge detect.
  assign z_meta_d = z;
  assign z_sync_d = z_meta_q;
  assign z_prev_d = z_sync_q;

  // A fault input ignores ZERO because the encoder is held in reset then.
  // Setting the fault takes priority over clearing it.
  always_comb begin
    fault_sticky_d = fault_sticky_q;
    if (!enc_faultn && (state_q != ST_ZERO)) begin
      fault_sticky_d = 1'b1;
    end else if (clr_req && enc_faultn) begin
      fault_sticky_d = 1'b0;
    end
  end

  // Velocity window.
  // The counter only matches sample_period-1 exactly.
  // A shrunken period therefore lets it run on and wrap without a pulse.
  always_comb begin
    win_cnt_d        = win_cnt_q;
    last_count_d     = last_count_q;
    velocity_d       = velocity_q;
    velocity_valid_d = 1'b0;
    if (state_q == ST_ZERO) begin
      win_cnt_d    = '0;
      last_count_d = '0;
    end else if (sample_period == '0) begin
      win_cnt_d = '0;
    end else if (win_cnt_q == (sample_period - PERIOD_W'(1))) begin
      win_cnt_d        = '0;
      last_count_d     = enc_count;
      velocity_valid_d = 1'b1;
      if (diff > VEL_MAX) begin
        velocity_d = VEL_MAX[VEL_W-1:0];
      end else if (diff < VEL_MIN) begin
        velocity_d = VEL_MIN[VEL_W-1:0];
      end else begin
        velocity_d = diff[VEL_W-1:0];
      end
    end else begin
      win_cnt_d = win_cnt_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= ST_IDLE;
      enc_resetn_q     <= 1'b0;
      velocity_q       <= '0;
      velocity_valid_q <= 1'b0;
      index_pos_q      <= '0;
      index_valid_q    <= 1'b0;
      fault_sticky_q   <= 1'b0;
      win_cnt_q        <= '0;
      last_count_q     <= '0;
      z_meta_q         <= 1'b0;
      z_sync_q         <= 1'b0;
      z_prev_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      enc_resetn_q     <= enc_resetn_d;
      velocity_q       <= velocity_d;
      velocity_valid_q <= velocity_valid_d;
      index_pos_q      <= index_pos_d;
      index_valid_q    <= index_valid_d;
      fault_sticky_q   <= fault_sticky_d;
      win_cnt_q        <= win_cnt_d;
      last_count_q     <= last_count_d;
      z_meta_q         <= z_meta_d;
      z_sync_q         <= z_sync_d;
      z_prev_q         <= z_prev_d;
    end
  end

endmodule

// File: tb/tb_quad_enc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_quad_enc_ctrl
//
// Directed bench for quad_enc_ctrl.
// Two instances share all inputs:
//   - dut uses VEL_W=32.
//   - dut8 uses VEL_W=8, to show velocity saturation.
// Inputs change 1 time unit after the rising edge.
// Outputs are read at the same point, so registered values are stable.
// -----------------------------------------------------------------------------
module tb_quad_enc_ctrl;

  logic               clk;
  logic               resetn;
  logic [63:0]        enc_count;
  logic               enc_faultn;
  logic               z;
  logic               cmd_valid;
  logic [1:0]         cmd_op;
  logic [31:0]        sample_period;

  logic               cmd_ready;
  logic               enc_resetn;
  logic signed [31:0] velocity;
  logic               velocity_valid;
  logic [63:0]        index_pos;
  logic               index_valid;
  logic               fault_sticky;
  logic [1:0]         state;

  logic               cmd_ready8;
  logic               enc_resetn8;
  logic signed [7:0]  velocity8;
  logic               velocity_valid8;
  logic [63:0]        index_pos8;
  logic               index_valid8;
  logic               fault_sticky8;
  logic [1:0]         state8;

  int vec_cnt;
  int err_cnt;
  longint base;

  quad_enc_ctrl #(.VEL_W(32), .PERIOD_W(32)) dut (
    .clk(clk), .resetn(resetn), .enc_count(enc_count), .enc_faultn(enc_faultn),
    .z(z), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .sample_period(sample_period), .enc_resetn(enc_resetn),
    .velocity(velocity), .velocity_valid(velocity_valid),
    .index_pos(index_pos), .index_valid(index_valid),
    .fault_sticky(fault_sticky), .state(state)
  );

  quad_enc_ctrl #(.VEL_W(8), .PERIOD_W(32)) dut8 (
    .clk(clk), .resetn(resetn), .enc_count(enc_count), .enc_faultn(enc_faultn),
    .z(z), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready8),
    .sample_period(sample_period), .enc_resetn(enc_resetn8),
    .velocity(velocity8), .velocity_valid(velocity_valid8),
    .index_pos(index_pos8), .index_valid(index_valid8),
    .fault_sticky(fault_sticky8), .state(state8)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  task automatic test_reset();
    resetn = 1'b0; enc_count = '0; enc_faultn = 1'b1; z = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; sample_period = '0;
    repeat (3) step();
    vec_cnt++;
    if (enc_resetn !== 1'b0) begin
      err_cnt++; $display("FAIL rst_enc_resetn: got %b exp 0", enc_resetn);
    end
    vec_cnt++;
    if (cmd_ready !== 1'b0) begin
      err_cnt++; $display("FAIL rst_cmd_ready: got %b exp 0", cmd_ready);
    end
    resetn = 1'b1;
    step();
    vec_cnt++;
    if (enc_resetn !== 1'b1) begin
      err_cnt++; $display("FAIL rel_enc_resetn: got %b exp 1", enc_resetn);
    end
    repeat (3) step();
    vec_cnt++;
    if ({state, velocity, velocity_valid, index_pos, index_valid, fault_sticky} !== '0) begin
      err_cnt++;
      $display("FAIL idle_outputs: state=%0d vel=%0d vv=%b ipos=%0h iv=%b flt=%b exp all 0",
               state, velocity, velocity_valid, index_pos, index_valid, fault_sticky);
    end
    vec_cnt++;
    if (cmd_ready !== 1'b1) begin
      err_cnt++; $display("FAIL idle_cmd_ready: got %b exp 1", cmd_ready);
    end
  endtask

  task automatic test_zero();
    enc_count = 64'd1234;
    send_cmd(2'b01);
    // Cycle N+1
    enc_count = '0;
    vec_cnt++;
    if (state !== 2'b01 || cmd_ready !== 1'b0 || enc_resetn !== 1'b0) begin
      err_cnt++;
      $display("FAIL zero_n1: state=%0d rdy=%b enc_rstn=%b exp 1/0/0", state, cmd_ready, enc_resetn);
    end
    step();
    vec_cnt++;
    if (state !== 2'b00 || cmd_ready !== 1'b1 || enc_resetn !== 1'b1) begin
      err_cnt++;
      $display("FAIL zero_n2: state=%0d rdy=%b enc_rstn=%b exp 0/1/1", state, cmd_ready, enc_resetn);
    end
  endtask

  task automatic run_window(input longint delta);
    int early;
    int exp32;
    int exp8;
    early = 0;
    exp32 = int'(delta * 100);
    exp8  = (exp32 > 127) ? 127 : ((exp32 < -128) ? -128 : exp32);
    for (int k = 1; k <= 100; k++) begin
      enc_count = 64'(base + delta * longint'(k));
      step();
      if (k < 100 && (velocity_valid || velocity_valid8)) early++;
    end
    base = base + delta * 100;
    vec_cnt++;
    if (early != 0) begin
      err_cnt++; $display("FAIL vel_early_pulse d=%0d: got %0d pulses exp 0", delta, early);
    end
    vec_cnt++;
    if (velocity_valid !== 1'b1 || velocity !== exp32) begin
      err_cnt++;
      $display("FAIL vel32 d=%0d: vv=%b vel=%0d exp 1/%0d", delta, velocity_valid, velocity, exp32);
    end
    vec_cnt++;
    if (velocity_valid8 !== 1'b1 || velocity8 !== exp8) begin
      err_cnt++;
      $display("FAIL vel8 d=%0d: vv=%b vel=%0d exp 1/%0d", delta, velocity_valid8, velocity8, exp8);
    end
  endtask

  task automatic test_velocity();
    base = 0;
    enc_count = '0;
    sample_period = 32'd100;
    run_window(5);
    run_window(3);
    run_window(-3);
    run_window(10);
    // Period of one: every edge is a sample.
    sample_period = 32'd1;
    enc_count = 64'(base + 7);
    step();
    vec_cnt++;
    if (velocity_valid !== 1'b1 || velocity !== 32'sd7) begin
      err_cnt++; $display("FAIL vel_p1_a: vv=%b vel=%0d exp 1/7", velocity_valid, velocity);
    end
    enc_count = 64'(base + 9);
    step();
    vec_cnt++;
    if (velocity_valid !== 1'b1 || velocity !== 32'sd2) begin
      err_cnt++; $display("FAIL vel_p1_b: vv=%b vel=%0d exp 1/2", velocity_valid, velocity);
    end
    sample_period = '0;
    repeat (5) step();
    vec_cnt++;
    if (velocity_valid !== 1'b0) begin
      err_cnt++; $display("FAIL vel_disabled: vv=%b exp 0", velocity_valid);
    end
  endtask

  task automatic test_index();
    int seen;
    send_cmd(2'b10);
    vec_cnt++;
    if (state !== 2'b10) begin
      err_cnt++; $display("FAIL arm_state: got %0d exp 2", state);
    end
    enc_count = 64'h100;
    z = 1'b1;
    step();
    step();
    vec_cnt++;
    if (index_valid !== 1'b0) begin
      err_cnt++; $display("FAIL idx_early: got %b exp 0", index_valid);
    end
    step();
    vec_cnt++;
    if (index_valid !== 1'b1 || index_pos !== 64'h100 || state !== 2'b00) begin
      err_cnt++;
      $display("FAIL idx_capture: iv=%b pos=%0h state=%0d exp 1/100/0", index_valid, index_pos, state);
    end
    step();
    vec_cnt++;
    if (index_valid !== 1'b0) begin
      err_cnt++; $display("FAIL idx_pulse_width: got %b exp 0", index_valid);
    end
    z = 1'b0;
    repeat (4) step();
    // Second pulse while IDLE must be ignored.
    seen = 0;
    enc_count = 64'h555;
    z = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (index_valid) seen++;
    end
    z = 1'b0;
    repeat (4) step();
    vec_cnt++;
    if (seen != 0 || index_pos !== 64'h100) begin
      err_cnt++; $display("FAIL idx_idle_ignored: pulses=%0d pos=%0h exp 0/100", seen, index_pos);
    end
  endtask

  task automatic test_fault();
    enc_faultn = 1'b0;
    step();
    enc_faultn = 1'b1;
    vec_cnt++;
    if (fault_sticky !== 1'b1) begin
      err_cnt++; $display("FAIL fault_set: got %b exp 1", fault_sticky);
    end
    step();
    vec_cnt++;
    if (fault_sticky !== 1'b1) begin
      err_cnt++; $display("FAIL fault_hold: got %b exp 1", fault_sticky);
    end
    enc_faultn = 1'b0;
    send_cmd(2'b11);
    enc_faultn = 1'b1;
    vec_cnt++;
    if (fault_sticky !== 1'b1) begin
      err_cnt++; $display("FAIL fault_set_wins: got %b exp 1", fault_sticky);
    end
    send_cmd(2'b11);
    vec_cnt++;
    if (fault_sticky !== 1'b0) begin
      err_cnt++; $display("FAIL fault_clear: got %b exp 0", fault_sticky);
    end
  endtask

  task automatic test_index_with_cmd();
    // Index edge coincident with NOP -> capture and IDLE.
    send_cmd(2'b10);
    enc_count = 64'h2AA;
    z = 1'b1;
    step();
    step();
    send_cmd(2'b00);
    vec_cnt++;
    if (index_valid !== 1'b1 || index_pos !== 64'h2AA || state !== 2'b00) begin
      err_cnt++;
      $display("FAIL idx_cmd_nop: iv=%b pos=%0h state=%0d exp 1/2aa/0", index_valid, index_pos, state);
    end
    z = 1'b0;
    repeat (4) step();
    // Index edge coincident with ARM -> capture and stay ARMED.
    send_cmd(2'b10);
    enc_count = 64'h3C3;
    z = 1'b1;
    step();
    step();
    send_cmd(2'b10);
    vec_cnt++;
    if (index_valid !== 1'b1 || index_pos !== 64'h3C3 || state !== 2'b10) begin
      err_cnt++;
      $display("FAIL idx_cmd_arm: iv=%b pos=%0h state=%0d exp 1/3c3/2", index_valid, index_pos, state);
    end
    send_cmd(2'b00);
    vec_cnt++;
    if (state !== 2'b00) begin
      err_cnt++; $display("FAIL arm_cancel: state=%0d exp 0", state);
    end
    z = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_index_no_cmd();
    send_cmd(2'b10);
    enc_count = 64'h777;
    z = 1'b1;
    repeat (3) step();
    vec_cnt++;
    if (index_valid !== 1'b1 || index_pos !== 64'h777) begin
      err_cnt++; $display("FAIL idx_nocmd_cap: iv=%b pos=%0h exp 1/777", index_valid, index_pos);
    end
`ifdef QUAD_ENC_INDEX_AUTOZERO_EN
    vec_cnt++;
    if (state !== 2'b01 || enc_resetn !== 1'b0) begin
      err_cnt++; $display("FAIL autozero: state=%0d enc_rstn=%b exp 1/0", state, enc_resetn);
    end
`else
    vec_cnt++;
    if (state !== 2'b00 || enc_resetn !== 1'b1) begin
      err_cnt++; $display("FAIL idx_nocmd_idle: state=%0d enc_rstn=%b exp 0/1", state, enc_resetn);
    end
`endif
    step();
    vec_cnt++;
    if (state !== 2'b00 || enc_resetn !== 1'b1) begin
      err_cnt++; $display("FAIL idx_nocmd_after: state=%0d enc_rstn=%b exp 0/1", state, enc_resetn);
    end
    z = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    send_cmd(2'b10);
    enc_faultn = 1'b0;
    step();
    enc_faultn = 1'b1;
    resetn = 1'b0;
    step();
    vec_cnt++;
    if (state !== 2'b00 || fault_sticky !== 1'b0 || enc_resetn !== 1'b0 ||
        cmd_ready !== 1'b0 || index_pos !== 64'h0) begin
      err_cnt++;
      $display("FAIL mid_reset: state=%0d flt=%b enc_rstn=%b rdy=%b pos=%0h exp 0/0/0/0/0",
               state, fault_sticky, enc_resetn, cmd_ready, index_pos);
    end
    resetn = 1'b1;
    step();
    vec_cnt++;
    if (enc_resetn !== 1'b1 || cmd_ready !== 1'b1) begin
      err_cnt++; $display("FAIL mid_release: enc_rstn=%b rdy=%b exp 1/1", enc_resetn, cmd_ready);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_zero();
    test_velocity();
    test_index();
    test_fault();
    test_index_with_cmd();
    test_index_no_cmd();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
